// File: rtl/pc_fetch_controller_if.sv
// rtl/pc_fetch_controller_if.sv - fetch controller signal bundle
//
// Groups the hazard/branch inputs, the instruction-memory handshake and the
// IF/ID-facing fetch result of pc_fetch_controller.
//   master : the fetch controller (drives imem_req/imem_addr and fetch results)
//   slave  : its environment (hazard unit, branch unit, instruction memory)
// Signals:
//   stall                     hold fetch (sampled in BOOT/STALL and on ack)
//   branch_taken/branch_target redirect pulse and target
//   jump/jump_target          redirect pulse and target, wins over branch
//   imem_req/imem_addr        fetch request and address (current PC)
//   imem_ack                  memory accepted the request this cycle
//   fetch_valid/fetch_pc      registered result of the last good fetch
//   align_fault               sticky misaligned-target flag
interface pc_fetch_controller_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        align_fault;

  modport master (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_ack,
    output imem_req, imem_addr, fetch_valid, fetch_pc, align_fault
  );

  modport slave (
    output stall, branch_taken, branch_target, jump, jump_target, imem_ack,
    input  imem_req, imem_addr, fetch_valid, fetch_pc, align_fault
  );
endinterface

// File: rtl/pc_fetch_controller.sv
// rtl/pc_fetch_controller.sv - program counter and instruction fetch sequencer
//
// Holds the PC, issues one instruction-memory request at a time, advances by
// 4 per acknowledged fetch and applies jump/branch redirects, squashing the
// fetch that was in flight when a redirect arrived during a request.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pc_fetch_controller_if.master (see interface file for signals)
// Parameter:
//   RESET_ADDR  word-aligned PC loaded on reset
// Build option:
//   PC_ALIGN_CHECK_EN  misaligned redirect targets set align_fault and are
//                      dropped; otherwise target bits [1:0] are masked to 0.
module pc_fetch_controller #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input logic                    clk,
  input logic                    rst,
  pc_fetch_controller_if.master  bus
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_STALL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        fetch_vld_q, fetch_vld_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        align_fault_q, align_fault_d;

  logic [31:0] redir_raw;
  logic [31:0] redir_tgt;
  logic        redir_ok;
  logic        fault_set;
  logic        squash;

  always_comb begin
    redir_raw = bus.jump ? bus.jump_target : bus.branch_target;
`ifdef PC_ALIGN_CHECK_EN
    redir_tgt = redir_raw;
    redir_ok  = (bus.jump | bus.branch_taken) && (redir_raw[1:0] == 2'b00);
    fault_set = (bus.jump | bus.branch_taken) && (redir_raw[1:0] != 2'b00);
`else
    redir_tgt = redir_raw & ~32'h3;
    redir_ok  = bus.jump | bus.branch_taken;
    fault_set = 1'b0;
`endif
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_vld_d    = pend_vld_q;
    pend_tgt_d    = pend_tgt_q;
    fetch_vld_d   = 1'b0;
    fetch_pc_d    = fetch_pc_q;
    align_fault_d = align_fault_q | fault_set;
    squash        = 1'b0;

    case (state_q)
      S_REQ: begin
        if (bus.imem_ack) begin
          // A redirect seen now or while the request waited kills this fetch.
          squash     = redir_ok | pend_vld_q;
          pc_d       = redir_ok   ? redir_tgt  :
                       pend_vld_q ? pend_tgt_q : pc_q + 32'd4;
          pend_vld_d = 1'b0;
          if (!squash) begin
            fetch_vld_d = 1'b1;
            fetch_pc_d  = pc_q;
          end
          state_d = bus.stall ? S_STALL : S_REQ;
        end else if (redir_ok) begin
          // Outstanding request keeps its address; remember the newest target.
          pend_vld_d = 1'b1;
          pend_tgt_d = redir_tgt;
        end
      end
      default: begin
        // BOOT and STALL: no request in flight, so redirect the PC directly.
        if (redir_ok) pc_d = redir_tgt;
        if (!bus.stall) state_d = S_REQ;
      end
    endcase

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_ADDR;
      req_q         <= 1'b0;
      pend_vld_q    <= 1'b0;
      pend_tgt_q    <= 32'h0;
      fetch_vld_q   <= 1'b0;
      fetch_pc_q    <= 32'h0;
      align_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_q         <= req_d;
      pend_vld_q    <= pend_vld_d;
      pend_tgt_q    <= pend_tgt_d;
      fetch_vld_q   <= fetch_vld_d;
      fetch_pc_q    <= fetch_pc_d;
      align_fault_q <= align_fault_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.fetch_valid = fetch_vld_q;
  assign bus.fetch_pc    = fetch_pc_q;
  assign bus.align_fault = align_fault_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb/tb_pc_fetch_controller.sv - scoreboard bench for pc_fetch_controller
module tb_pc_fetch_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_controller_if bus ();
  pc_fetch_controller_if bus_w ();

  pc_fetch_controller #(.RESET_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  pc_fetch_controller #(.RESET_ADDR(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] addr_q[$];
  logic [31:0] fv_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake and fetch-result monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (addr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_handshake actual=%h required=none", bus.imem_addr);
        end else begin
          chk("handshake_addr", bus.imem_addr, addr_q.pop_front());
        end
      end
      if (bus.fetch_valid) begin
        if (fv_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_fetch_valid actual=%h required=none", bus.fetch_pc);
        end else begin
          chk("fetch_pc", bus.fetch_pc, fv_q.pop_front());
        end
      end
    end
  end

  logic [31:0] p;

  initial begin
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    bus.jump = 0; bus.jump_target = 0; bus.imem_ack = 0;
    bus_w.stall = 0; bus_w.branch_taken = 0; bus_w.branch_target = 0;
    bus_w.jump = 0; bus_w.jump_target = 0; bus_w.imem_ack = 1;

    // Reset values
    tick(); tick();
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("rst_fpc", bus.fetch_pc, 32'h0);
    chk("rst_align", {31'b0, bus.align_fault}, 32'h0);
    chk("rst_addr_w", bus_w.imem_addr, 32'hFFFF_FFFC);

    // Boot with ack tied high: 0,4,8,C then land on 0x10
    foreach (addr_q[i]) addr_q.delete(i);
    addr_q.push_back(32'h0); addr_q.push_back(32'h4);
    addr_q.push_back(32'h8); addr_q.push_back(32'hC);
    fv_q.push_back(32'h0); fv_q.push_back(32'h4);
    fv_q.push_back(32'h8); fv_q.push_back(32'hC);
    rst = 0; bus.imem_ack = 1;
    tick();
    chk("boot_req", {31'b0, bus.imem_req}, 32'h1);
    chk("boot_fv0", {31'b0, bus.fetch_valid}, 32'h0);
    chk("wrap_addr0", bus_w.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", bus_w.imem_addr, 32'h0000_0000);
    chk("wrap_fpc", bus_w.fetch_pc, 32'hFFFF_FFFC);
    tick(); tick(); tick();
    bus.imem_ack = 0;

    // Held request at 0x10
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_addr", bus.imem_addr, 32'h10);
      chk("held_req", {31'b0, bus.imem_req}, 32'h1);
    end
    addr_q.push_back(32'h10); addr_q.push_back(32'h14);
    addr_q.push_back(32'h18); addr_q.push_back(32'h1C);
    fv_q.push_back(32'h10); fv_q.push_back(32'h14);
    fv_q.push_back(32'h18); fv_q.push_back(32'h1C);
    bus.imem_ack = 1;
    tick();
    chk("after_held_addr", bus.imem_addr, 32'h14);
    tick(); tick(); tick();
    bus.imem_ack = 0;
    chk("wait_addr_20", bus.imem_addr, 32'h20);

    // Branch while waiting at 0x20: pending, then squash on ack
    bus.branch_taken = 1; bus.branch_target = 32'h100;
    tick();
    bus.branch_taken = 0;
    chk("pend_keep_addr", bus.imem_addr, 32'h20);
    tick();
    addr_q.push_back(32'h20);
    bus.imem_ack = 1;
    tick();
    chk("br_squash_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("br_target", bus.imem_addr, 32'h100);
    addr_q.push_back(32'h100);
    tick();
    fv_q.push_back(32'h100);
    bus.imem_ack = 0;

    // Jump and branch together while waiting at 0x104: jump wins
    bus.jump = 1; bus.jump_target = 32'h200;
    bus.branch_taken = 1; bus.branch_target = 32'h300;
    tick();
    bus.jump = 0; bus.branch_taken = 0;
    addr_q.push_back(32'h104);
    bus.imem_ack = 1;
    tick();
    chk("jmp_squash_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("jmp_target", bus.imem_addr, 32'h200);
    addr_q.push_back(32'h200);
    tick();
    fv_q.push_back(32'h200);

    // Same-cycle redirect with ack, misaligned target 0x102
    addr_q.push_back(32'h204);
    bus.branch_taken = 1; bus.branch_target = 32'h102;
    tick();
    bus.branch_taken = 0;
`ifdef PC_ALIGN_CHECK_EN
    fv_q.push_back(32'h204);
    chk("align_fault", {31'b0, bus.align_fault}, 32'h1);
    chk("align_seq_addr", bus.imem_addr, 32'h208);
    p = 32'h208;
`else
    chk("align_fault_tied", {31'b0, bus.align_fault}, 32'h0);
    chk("mask_target", bus.imem_addr, 32'h100);
    chk("same_cyc_squash", {31'b0, bus.fetch_valid}, 32'h0);
    p = 32'h100;
`endif

    // Stall across an ack, jump during stall, release without squash
    bus.stall = 1;
    addr_q.push_back(p);
    fv_q.push_back(p);
    tick();
    chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
    chk("stall_pc", bus.imem_addr, p + 32'd4);
    bus.imem_ack = 0;
    bus.jump = 1; bus.jump_target = 32'h80;
    tick();
    bus.jump = 0;
    chk("stall_jmp_addr", bus.imem_addr, 32'h80);
    chk("stall_req2", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("stall_req3", {31'b0, bus.imem_req}, 32'h0);
    bus.stall = 0; bus.imem_ack = 1;
    addr_q.push_back(32'h80);
    fv_q.push_back(32'h80);
    tick();
    chk("release_req", {31'b0, bus.imem_req}, 32'h1);
    chk("release_addr", bus.imem_addr, 32'h80);
    tick();
    bus.imem_ack = 0;
    chk("release_next", bus.imem_addr, 32'h84);

    // Asynchronous reset mid-request with a pending redirect
    bus.branch_taken = 1; bus.branch_target = 32'h300;
    tick();
    bus.branch_taken = 0;
    #2;
    rst = 1;
    #1;
    chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_fv", {31'b0, bus.fetch_valid}, 32'h0);
    chk("arst_fpc", bus.fetch_pc, 32'h0);
    tick();
    rst = 0; bus.imem_ack = 1;
    addr_q.push_back(32'h0);
    fv_q.push_back(32'h0);
    tick();
    tick();
    chk("arst_pend_lost", bus.imem_addr, 32'h4);
    bus.imem_ack = 0;
    tick(); tick();

    chk("addr_q_drained", addr_q.size(), 32'd0);
    chk("fv_q_drained", fv_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
